bin_to_bcd_seq: RTL and testbench

BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

---
 rtl/bcd_pkg.sv | 16 +
 rtl/bin_to_bcd_seq_bcd_digit_adj.sv | 17 +
 rtl/bin_to_bcd_seq.sv | 115 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared defaults, FSM state type and double-dabble adjust constants
// for the sequential binary-to-BCD converter.
package bcd_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int DIGITS_DEF = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_digit_adj.sv
// Combinational double-dabble cell: adds 3 to a BCD digit that is
// 5 or more, so the following left shift carries into the next digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] q
);

    always_comb begin
        q = d;
        if (d >= ADJ_THRESHOLD) begin
            q = d + ADJ_ADD;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Optional BIN2BCD_AUTOSTART_EN: auto-convert when bin_in changes.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int DIGITS = DIGITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out
);

    localparam int DW = DIGITS * 4;
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [DW-1:0]   scr_q, scr_d;
    logic [DW-1:0]   bcd_q, bcd_d;
    logic            done_q, done_d;
    logic [DW-1:0]   adj;
    logic            go;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (scr_q[g*4 +: 4]),
            .q (adj[g*4 +: 4])
        );
    end

`ifdef BIN2BCD_AUTOSTART_EN
    logic [WIDTH-1:0] last_q, last_d;

    assign go = start || (bin_in != last_q);

    always_comb begin
        last_d = last_q;
        if (state_q == IDLE && go) begin
            last_d = bin_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= '0;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign go = start;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    sh_d    = bin_in;
                    scr_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                scr_d = {adj[DW-2:0], sh_q[WIDTH-1]};
                sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                // last shift: publish the finished scratch, never partials
                if (cnt_q == LAST) begin
                    bcd_d   = scr_d;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        busy    = (state_q == SHIFT);
        done    = done_q;
        bcd_out = bcd_q;
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq.
// Define BIN2BCD_AUTOSTART_EN to exercise the autostart build instead.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  bin_in = '0;
    logic        busy;
    logic        done;
    logic [11:0] bcd_out;

    int n_vec = 0;
    int n_bad = 0;
    logic [11:0] hold = '0;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
    } vec_t;

    vec_t tbl [11];

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic convert(input logic [7:0] v, input logic [11:0] exp);
        int n;
        bin_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bin_in = ~v;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n = i;
            if (done) break;
            check("busy_mid", busy, 1);
            check("hold_mid", bcd_out, hold);
        end
        check("latency", n, 8);
        check("bcd", bcd_out, exp);
        check("busy_at_done", busy, 0);
        hold = exp;
        tick();
        check("done_clear", done, 0);
        check("bcd_hold", bcd_out, exp);
    endtask

`ifdef BIN2BCD_AUTOSTART_EN
    initial begin
        int ndone;
        logic seen255;
        logic wrap_ok;
        ndone   = 0;
        seen255 = 1'b0;
        wrap_ok = 1'b0;
        bin_in  = 8'd250;
        #5;
        check("rst_bcd", bcd_out, 0);
        check("rst_busy", busy, 0);
        #10 reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i % 10 == 9) bin_in = bin_in + 8'd1;
            if (done) begin
                ndone++;
                check("auto_bcd", bcd_out, to_bcd(int'(bin_in)));
                if (seen255 && bcd_out == 12'h000) wrap_ok = 1'b1;
                seen255 = (bcd_out == 12'h255);
            end
        end
        check("auto_count", int'(ndone >= 15), 1);
        check("auto_wrap", wrap_ok, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
`else
    initial begin
        int cnt;
        int t0;
        int gaps [2];
        tbl[0]  = '{8'd255, 12'h255};
        tbl[1]  = '{8'd0,   12'h000};
        tbl[2]  = '{8'd99,  12'h099};
        tbl[3]  = '{8'd100, 12'h100};
        tbl[4]  = '{8'd1,   12'h001};
        tbl[5]  = '{8'd9,   12'h009};
        tbl[6]  = '{8'd10,  12'h010};
        tbl[7]  = '{8'd128, 12'h128};
        tbl[8]  = '{8'd199, 12'h199};
        tbl[9]  = '{8'd55,  12'h055};
        tbl[10] = '{8'd123, 12'h123};

        #5;
        check("rst_bcd", bcd_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        #10 reset = 1'b0;
        tick();

        for (int i = 0; i < 11; i++) begin
            convert(tbl[i].bin, tbl[i].bcd);
        end

        // second start two cycles into a conversion must be dropped
        bin_in = 8'd42;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        tick();
        bin_in = 8'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (done) cnt++;
        end
        check("ign_pulses", cnt, 1);
        check("ign_bcd", bcd_out, 12'h042);
        check("ign_idle", busy, 0);

        // reset four cycles into a conversion
        bin_in = 8'd200;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_bcd", bcd_out, 0);
        tick();
        reset = 1'b0;
        hold  = '0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) cnt++;
        end
        check("post_rst_quiet", cnt, 0);
        convert(8'd200, 12'h200);

        // start held: back-to-back every WIDTH+1 cycles
        bin_in = 8'd123;
        start  = 1'b1;
        cnt = 0;
        t0  = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done) begin
                check("b2b_bcd", bcd_out, 12'h123);
                if (cnt > 0 && cnt < 3) gaps[cnt-1] = i - t0;
                t0 = i;
                cnt++;
            end
        end
        start = 1'b0;
        check("b2b_count", int'(cnt >= 3), 1);
        check("b2b_gap0", gaps[0], 9);
        check("b2b_gap1", gaps[1], 9);
        cnt = 0;
        for (int i = 0; i < 12 && busy; i++) tick();
        check("b2b_drain", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
`endif

endmodule
